// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared constants and fetch-state encoding for the
//                instruction-fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int unsigned c_ADDR_W   = 32;
    localparam int unsigned c_INST_W   = 32;
    localparam int unsigned c_PC_STEP  = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // Fetch FSM encoding: no request / request live, data kept /
    // request live, data dropped.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_ST_IDLE  = 2'd0;
    localparam fetch_state_t c_ST_FETCH = 2'd1;
    localparam fetch_state_t c_ST_FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_buf
//  Description : DEPTH-entry FIFO of {pc, inst} pairs between the fetch
//                engine and IF/ID. Synchronous flush, occupancy count,
//                head outputs come straight from storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_pc,
    input  logic [INST_W-1:0]        i_push_inst,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_valid,
    output logic [ADDR_W-1:0]        o_head_pc,
    output logic [INST_W-1:0]        o_head_inst,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
    logic [INST_W-1:0]  r_inst_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Pops of an empty FIFO are ignored; a flush wins over a push.
    assign w_do_pop  = i_pop & o_valid;
    assign w_do_push = i_push & ~i_flush;

    // Pointer and occupancy tracking; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

    // Entry storage; cleared at reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
            r_inst_mem[r_wr_ptr] <= i_push_inst;
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_head_pc   = r_pc_mem[r_rd_ptr];
    assign o_head_inst = r_inst_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch front end. Single-outstanding req/ack
//                fetch engine with branch/jump redirect and a small fetch
//                buffer feeding IF/ID over valid/ready.
//                Optional build macro IF_PERF_CNT_EN adds perf_fetched /
//                perf_bubble counters and ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = c_ADDR_W,
    parameter int unsigned       INST_W    = c_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(c_RESET_PC),
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble
`endif
);

    localparam int unsigned       c_CNT_W       = $clog2(BUF_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] c_STEP        = ADDR_W'(c_PC_STEP);
    localparam logic [ADDR_W-1:0] c_RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_imem_req;
    logic              w_imem_req_nxt;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [ADDR_W-1:0] w_imem_addr_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_room;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [ADDR_W-1:0] w_redir_pc;

    // Low address bits of a redirect target are meaningless for word fetch.
    assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Only data for a kept request is buffered; any redirect flushes, but a
    // pop in the same cycle (the delay slot) still leaves IF.
    assign w_pop   = if_valid & id_ready;
    assign w_push  = (r_state == c_ST_FETCH) & imem_ack & ~redirect_valid;
    assign w_flush = redirect_valid;

    // Occupancy after this cycle decides whether another request fits.
    assign w_count_nxt = w_flush ? '0
                                 : (w_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop));
    assign w_room      = (w_count_nxt < c_DEPTH);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!redirect_valid && w_room) w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (redirect_valid)         w_state_nxt = imem_ack ? c_ST_FETCH : c_ST_FLUSH;
                else if (imem_ack && !w_room) w_state_nxt = c_ST_IDLE;
            end
            c_ST_FLUSH: begin
                if (imem_ack) w_state_nxt = c_ST_FETCH;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Request/PC actions per state; request fields hold while unacked.
    always_comb begin
        w_imem_req_nxt  = r_imem_req;
        w_imem_addr_nxt = r_imem_addr;
        w_fetch_pc_nxt  = r_fetch_pc;
        case (r_state)
            c_ST_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redir_pc;
                end else if (w_room) begin
                    w_imem_req_nxt  = 1'b1;
                    w_imem_addr_nxt = r_fetch_pc;
                    w_fetch_pc_nxt  = r_fetch_pc + c_STEP;
                end
            end
            c_ST_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        w_imem_addr_nxt = w_redir_pc;
                        w_fetch_pc_nxt  = w_redir_pc + c_STEP;
                    end else begin
                        w_fetch_pc_nxt  = w_redir_pc;
                    end
                end else if (imem_ack) begin
                    if (w_room) begin
                        w_imem_addr_nxt = r_fetch_pc;
                        w_fetch_pc_nxt  = r_fetch_pc + c_STEP;
                    end else begin
                        w_imem_req_nxt  = 1'b0;
                    end
                end
            end
            c_ST_FLUSH: begin
                // A redirect landing together with the stale ack goes
                // straight to the new target.
                if (imem_ack) begin
                    w_imem_addr_nxt = redirect_valid ? w_redir_pc : r_fetch_pc;
                    w_fetch_pc_nxt  = (redirect_valid ? w_redir_pc : r_fetch_pc) + c_STEP;
                end else if (redirect_valid) begin
                    w_fetch_pc_nxt  = w_redir_pc;
                end
            end
            default: begin
                w_imem_req_nxt = 1'b0;
            end
        endcase
    end

    // Request and fetch-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= c_RESET_PC_AL;
            r_fetch_pc  <= c_RESET_PC_AL;
        end else begin
            r_imem_req  <= w_imem_req_nxt;
            r_imem_addr <= w_imem_addr_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;

    if_fetch_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_pc   (r_imem_addr),
        .i_push_inst (imem_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_valid     (if_valid),
        .o_head_pc   (if_pc),
        .o_head_inst (if_inst),
        .o_count     (w_count)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;

    // Delivered-instruction and bubble counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
        end else begin
            if (w_pop)                  r_perf_fetched <= r_perf_fetched + 32'd1;
            if (id_ready && !if_valid)  r_perf_bubble  <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubble  = r_perf_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Directed self-checking bench for if_fetch with a simple
//                programmable-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    int   total = 0;
    int   bad   = 0;
    int   lat   = 0;
    logic mem_en = 1'b1;
    int   wcnt  = 0;

    if_fetch #(
        .ADDR_W    (32),
        .INST_W    (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubble    (perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign imem_data = mdata(imem_addr);
    assign imem_ack  = imem_req && mem_en && (wcnt >= lat);

    // Wait-state counter of the memory model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else                          wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        mem_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        id_ready = 1'b1;
        lat = 0;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        total++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin bad++; $display("FAIL reset_head: got pc=%h inst=%h want 0/0", if_pc, if_inst); end
`ifdef IF_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd0 || perf_bubble !== 32'd0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_bubble); end
`endif
        rst_n = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        id_ready = 1'b1;
        lat = 0;
        do_reset();
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stream_first: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        for (int k = 2; k <= 7; k++) begin
            tick();
            want = 32'(4 * (k - 1));
            total++; if (imem_addr !== want) begin bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, want); end
            want = 32'(4 * (k - 2));
            total++; if (if_valid !== 1'b1 || if_pc !== want || if_inst !== mdata(want)) begin bad++; $display("FAIL stream_head: got v=%b pc=%h inst=%h want 1/%h/%h", if_valid, if_pc, if_inst, want, mdata(want)); end
        end
`ifdef IF_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd5 || perf_bubble !== 32'd2) begin bad++; $display("FAIL stream_perf: got %0d/%0d want 5/2", perf_fetched, perf_bubble); end
`endif
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        total++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_full: got req=%b v=%b pc=%h want 0/1/00000000", imem_req, if_valid, if_pc); end
        tick();
        total++; if (imem_req !== 1'b0 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_idle: got req=%b pc=%h want 0/00000000", imem_req, if_pc); end
        id_ready = 1'b1;
        tick();
        total++; if (if_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL stall_resume: got pc=%h req=%b addr=%h want 4/1/8", if_pc, imem_req, imem_addr); end
        tick();
        total++; if (if_pc !== 32'h8 || if_inst !== mdata(32'h8) || imem_addr !== 32'hC) begin bad++; $display("FAIL stall_after: got pc=%h inst=%h addr=%h want 8/%h/c", if_pc, if_inst, imem_addr, mdata(32'h8)); end
    endtask

    task automatic test_latency();
        id_ready = 1'b1;
        lat = 3;
        do_reset();
        tick();
        for (int k = 2; k <= 4; k++) begin
            tick();
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL lat_hold: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin bad++; $display("FAIL lat_first: got v=%b pc=%h addr=%h want 1/0/4", if_valid, if_pc, imem_addr); end
        for (int k = 6; k <= 8; k++) begin
            tick();
            total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL lat_gap: got v=%b want 0", if_valid); end
        end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin bad++; $display("FAIL lat_second: got v=%b pc=%h want 1/4", if_valid, if_pc); end
`ifdef IF_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd1 || perf_bubble !== 32'd8) begin bad++; $display("FAIL lat_perf: got %0d/%0d want 1/8", perf_fetched, perf_bubble); end
`endif
        lat = 0;
    endtask

    task automatic test_flush_pending();
        id_ready = 1'b1;
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL flush_pre: got addr=%h want 8", imem_addr); end
        mem_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin bad++; $display("FAIL flush_enter: got req=%b addr=%h v=%b want 1/8/0", imem_req, imem_addr, if_valid); end
        tick();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL flush_hold: got addr=%h want 8", imem_addr); end
        mem_en = 1'b1;
        tick();
        total++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got addr=%h v=%b want 100/0", imem_addr, if_valid); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mdata(32'h100)) begin bad++; $display("FAIL flush_target: got v=%b pc=%h inst=%h want 1/100/%h", if_valid, if_pc, if_inst, mdata(32'h100)); end
    endtask

    task automatic test_delay_slot();
        id_ready = 1'b0;
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b0) begin bad++; $display("FAIL ds_head: got v=%b pc=%h req=%b want 1/4/0", if_valid, if_pc, imem_req); end
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL ds_flushed: got v=%b req=%b want 0/0", if_valid, imem_req); end
`ifdef IF_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd2) begin bad++; $display("FAIL ds_perf: got %0d want 2", perf_fetched); end
`endif
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL ds_req: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== mdata(32'h200)) begin bad++; $display("FAIL ds_target: got v=%b pc=%h inst=%h want 1/200/%h", if_valid, if_pc, if_inst, mdata(32'h200)); end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1;
        lat = 0;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin bad++; $display("FAIL wrap_req: got addr=%h v=%b want fffffffc/0", imem_addr, if_valid); end
        tick();
        total++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin bad++; $display("FAIL wrap_next: got addr=%h pc=%h v=%b want 0/fffffffc/1", imem_addr, if_pc, if_valid); end
        tick();
        total++; if (if_pc !== 32'h0 || imem_addr !== 32'h4 || if_inst !== mdata(32'h0)) begin bad++; $display("FAIL wrap_after: got pc=%h addr=%h inst=%h want 0/4/%h", if_pc, imem_addr, if_inst, mdata(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_flush_pending();
        test_delay_slot();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end, directly upstream of the IF/ID pipeline register. Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake. Applies branch/jump redirects and buffers returned words in a small FIFO that feeds IF/ID with a valid/ready handshake. It also absorbs variable memory latency and decode-stage stalls.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- ADDR_W, 32, address width
- INST_W, 32, instruction width
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  request address, registered, bits [1:0] always 0
- imem_ack  in  1  memory accepts request; imem_data valid same cycle
- imem_data  in  INST_W  returned instruction
- redirect_valid  in  1  branch/jump taken, from later stage
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored
- id_ready  in  1  IF/ID can accept (low = stall)
- if_valid  out  1  buffer head valid
- if_pc  out  ADDR_W  head PC
- if_inst  out  INST_W  head instruction
- perf_fetched  out  32  (IF_PERF_CNT_EN only) instructions delivered
- perf_bubble  out  32  (IF_PERF_CNT_EN only) bubble cycles

## Operation
- Registers: fetch_pc (next address to request), imem_addr (address in flight), state, buffer of {pc, inst}, count.
- States: IDLE (no request), FETCH (request live, data kept), FLUSH (request live, data dropped).
- Push on imem_ack in FETCH without redirect: entry {imem_addr, imem_data}. Pop when if_valid & id_ready.
- IDLE: if count_next < BUF_DEPTH → FETCH, imem_addr ← fetch_pc, fetch_pc += 4.
- FETCH, ack, no redirect: push; if count_next < BUF_DEPTH, stay with imem_addr ← fetch_pc, fetch_pc += 4; else → IDLE, imem_req ← 0.
- FETCH, redirect, ack: drop data, flush, imem_addr ← redirect_pc, fetch_pc ← redirect_pc+4, stay FETCH.
- FETCH, redirect, no ack: flush, fetch_pc ← redirect_pc, → FLUSH; imem_addr held until ack.
- FLUSH, ack: drop data, → FETCH with imem_addr ← fetch_pc, fetch_pc += 4. Redirect in FLUSH: fetch_pc ← redirect_pc, stay.
- IDLE, redirect: flush, fetch_pc ← redirect_pc, → IDLE, which proceeds to FETCH next cycle.
- Flush clears all entries. A pop in the redirect cycle still completes and is the delay slot. Nothing else survives.
- PC arithmetic is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0.
- imem_addr and imem_req stay stable while imem_req=1 and imem_ack=0.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, fetch_pc RESET_PC, state IDLE, count 0, if_valid 0, if_pc 0, if_inst 0, perf counters 0.
- First imem_req is one cycle after rst_n deasserts. Reset mid-request abandons it; the memory must tolerate a dropped req.
- Ack in cycle N means if_valid=1 in cycle N+1 at the earliest.
- With zero-wait memory and id_ready=1, throughput is 1 instruction/cycle with no bubbles.
- Redirect in cycle N means the first target instruction is valid in N+2 at the earliest.
- if_valid, if_pc and if_inst are driven from registers only. There is no combinational path from any input.

## Configuration
- IF_PERF_CNT_EN defined: perf_fetched increments per pop. perf_bubble increments per cycle with id_ready=1 and if_valid=0. Both wrap at 2^32.
- Not defined: the perf ports and counters are absent.

## Structure
- Shared package: fetch-state enum (IDLE/FETCH/FLUSH), ADDR_W/INST_W defaults, PC_STEP=4, RESET_PC default.
- Sub-module: if_fetch_buf. It is a BUF_DEPTH FIFO of {pc, inst} with push, pop, synchronous flush, count, and an async active-low reset.

## Test plan
- Reset release, zero-wait memory, id_ready=1 → addresses 0,4,8,… on consecutive cycles. if_pc follows one cycle later, with no bubbles.
- id_ready=0 from start → two entries buffered (0,4), then IDLE with imem_req=0. id_ready=1 → pops 0, then 4, then fetch resumes at 8.
- Memory ack delay of 3 cycles → imem_addr held stable 3 cycles, one instruction per 4 cycles, perf_bubble counts gaps.
- Redirect to 0x100 while request for 0x8 is unacked → FLUSH. Data for 0x8 is dropped, the next request is 0x100, and the buffer is empty.
- Redirect to 0x200 in the same cycle as a pop of 0x4 → 0x4 delivered, buffered 0x8 discarded, next if_pc is 0x200.
- redirect_pc=0xFFFF_FFFE → request 0xFFFF_FFFC, then 0x0.
